count_seq_checker: RTL and testbench
====================================

Name: count_seq_checker

Overview:
- Sits directly downstream of the free-running `counter` and consumes its `count` bus.
- Checks each sampled value against the previous one for a +1 (mod 2^WIDTH) increment.
- Declares lock after a run of good increments, flags errors and wrap events, and keeps saturating tallies of both.
- Used in-system as a health monitor and in benches as a self-checking scoreboard.

Parameters:
- WIDTH, 4: width of `count_in`; must match the upstream counter.
- LOCK_CNT, 3: consecutive good increments required to enter LOCKED; legal range 1..15.
- ERR_W, 8: width of `err_count` and `wrap_count`.

Ports:
- clk  in  1  rising-edge clock, shared with the upstream counter.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  sample enable; `count_in` is evaluated only on edges where en=1.
- clr  in  1  synchronous clear; returns to IDLE and zeroes counters; priority over en.
- count_in  in  WIDTH  value from the upstream counter.
- locked  out  1  high while state is LOCKED.
- err_pulse  out  1  one-cycle pulse on a mismatch detected in LOCKED.
- wrap_pulse  out  1  one-cycle pulse on a good max→0 transition in LOCKED.
- err_count  out  ERR_W  saturating count of err_pulse events.
- wrap_count  out  ERR_W  saturating count of wrap_pulse events.
- state  out  2  current FSM state (00 IDLE, 01 ACQUIRE, 10 LOCKED) for debug.

Behaviour:
- Reset:
  - rst_n low immediately forces state=IDLE and clears the internal `prev` register, `good_run`, and all outputs, independent of clk.
  - This applies mid-operation as well.
  - Release is sampled on the next rising edge.
- Outputs: all outputs are registered. A sampled value is reflected in the outputs immediately after the edge that samples it (latency 1 edge).
- Good increment: count_in == (prev + 1) mod 2^WIDTH, computed in WIDTH bits so that max→0 is good.
- IDLE: on an en edge, store prev=count_in, set good_run=0, go to ACQUIRE. No pulses.
- ACQUIRE, on each en edge:
  - Good increment: good_run++. If good_run reaches LOCK_CNT, go to LOCKED and assert locked.
  - Mismatch: good_run=0, stay in ACQUIRE, no err_pulse, no err_count change.
  - A wrap in ACQUIRE is a good increment but does not pulse or count.
- LOCKED, on each en edge:
  - Good increment: stay in LOCKED. If prev == 2^WIDTH−1 and count_in == 0, assert wrap_pulse and increment wrap_count.
  - Mismatch, including a repeated value: assert err_pulse, increment err_count, go to ACQUIRE with good_run=0, deassert locked.
- prev: updated to count_in on every en edge in every state.
- en=0 edges: state, prev, good_run and counters are held. Pulses are 0.
  - Freezing the upstream counter while en=0 is therefore not an error.
- clr=1 edge: state=IDLE, good_run=0, err_count=0, wrap_count=0, pulses=0, locked=0. The en sample on that edge is ignored.
- Saturation: err_count and wrap_count stop at 2^ERR_W−1. The corresponding pulse still fires.
- Pulses: never asserted for more than one cycle per sampled event. err_pulse and wrap_pulse are mutually exclusive.
- state encoding 11 is unused; if reached, the FSM goes to IDLE on the next edge.

Test Plan:
1. Lock: reset, en=1, count_in 0,1,2,3 on successive edges → locked=1 after the edge sampling 3; err_count=0, wrap_count=0, state=10.
2. Wrap: continue the count 4..15,0 → wrap_pulse high for exactly one cycle after the edge sampling 0; wrap_count=1; locked stays 1.
3. Error and relock: while locked, present 6,6,7,8,9 → err_pulse one cycle after the second 6; err_count=1, locked=0, state=01; locked=1 again after the edge sampling 9.
4. Enable gating: while locked at prev=5, hold en=0 for 2 edges with count_in=9, then en=1 with count_in=6 → no err_pulse, locked stays 1.
5. Saturation: ERR_W=2, force 5 locked mismatches, relocking between each → err_count sticks at 3; err_pulse fires 5 times.
6. Reset/clear: drop rst_n mid-cycle while locked with counters non-zero → all outputs 0 before the next edge. Repeat with clr=1 for one edge → same result on that edge, and relock resumes from IDLE.

Source files
------------

// File: rtl/count_seq_checker.sv
// count_seq_checker: watches an upstream free-running counter and confirms that
// every enabled sample is the previous sample plus one (mod 2^WIDTH). It locks
// after LOCK_CNT good increments in a row, pulses on errors and wraps while
// locked, and keeps saturating tallies of both.
module count_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] count_in,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [ERR_W-1:0] err_count,
  output logic [ERR_W-1:0] wrap_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ACQUIRE = 2'b01,
    ST_LOCKED  = 2'b10
  } state_t;

  state_t           r_state,      w_state_nxt;
  logic [WIDTH-1:0] r_prev,       w_prev_nxt;
  logic [3:0]       r_good_run,   w_good_run_nxt;
  logic [ERR_W-1:0] r_err_count,  w_err_count_nxt;
  logic [ERR_W-1:0] r_wrap_count, w_wrap_count_nxt;
  logic             r_err_pulse,  w_err_pulse_nxt;
  logic             r_wrap_pulse, w_wrap_pulse_nxt;

  logic [WIDTH-1:0] w_prev_inc;
  logic [3:0]       w_run_inc;
  logic             w_good;
  logic             w_wrap;

  // Increment is computed in WIDTH bits so max->0 counts as good.
  assign w_prev_inc = r_prev + WIDTH'(1);
  assign w_good     = (count_in == w_prev_inc);
  assign w_wrap     = w_good && (r_prev == '1);
  assign w_run_inc  = r_good_run + 4'd1;

  // Next-state, counter and pulse decode for the current sample.
  always_comb begin
    w_state_nxt      = r_state;
    w_prev_nxt       = r_prev;
    w_good_run_nxt   = r_good_run;
    w_err_count_nxt  = r_err_count;
    w_wrap_count_nxt = r_wrap_count;
    w_err_pulse_nxt  = 1'b0;
    w_wrap_pulse_nxt = 1'b0;

    if (clr) begin
      w_state_nxt      = ST_IDLE;
      w_good_run_nxt   = '0;
      w_err_count_nxt  = '0;
      w_wrap_count_nxt = '0;
    end else begin
      if (en) begin
        w_prev_nxt = count_in;
      end
      case (r_state)
        ST_IDLE: begin
          if (en) begin
            w_good_run_nxt = '0;
            w_state_nxt    = ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (en) begin
            if (w_good) begin
              if (w_run_inc == 4'(LOCK_CNT)) begin
                w_good_run_nxt = '0;
                w_state_nxt    = ST_LOCKED;
              end else begin
                w_good_run_nxt = w_run_inc;
              end
            end else begin
              w_good_run_nxt = '0;
            end
          end
        end
        ST_LOCKED: begin
          if (en) begin
            if (w_good) begin
              if (w_wrap) begin
                w_wrap_pulse_nxt = 1'b1;
                if (r_wrap_count != '1) begin
                  w_wrap_count_nxt = r_wrap_count + ERR_W'(1);
                end
              end
            end else begin
              w_err_pulse_nxt = 1'b1;
              if (r_err_count != '1) begin
                w_err_count_nxt = r_err_count + ERR_W'(1);
              end
              w_good_run_nxt = '0;
              w_state_nxt    = ST_ACQUIRE;
            end
          end
        end
        // Unused encoding recovers to IDLE on the next edge, enabled or not.
        default: begin
          w_good_run_nxt = '0;
          w_state_nxt    = ST_IDLE;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_prev       <= '0;
      r_good_run   <= '0;
      r_err_count  <= '0;
      r_wrap_count <= '0;
      r_err_pulse  <= 1'b0;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_prev       <= w_prev_nxt;
      r_good_run   <= w_good_run_nxt;
      r_err_count  <= w_err_count_nxt;
      r_wrap_count <= w_wrap_count_nxt;
      r_err_pulse  <= w_err_pulse_nxt;
      r_wrap_pulse <= w_wrap_pulse_nxt;
    end
  end

  assign locked     = (r_state == ST_LOCKED);
  assign err_pulse  = r_err_pulse;
  assign wrap_pulse = r_wrap_pulse;
  assign err_count  = r_err_count;
  assign wrap_count = r_wrap_count;
  assign state      = r_state;

endmodule

// File: tb/tb_count_seq_checker.sv
// Bench for count_seq_checker: directed scenarios followed by randomized
// stimulus, compared against a behavioural model. A second instance with a
// 2-bit tally width shares the stimulus to exercise saturation.
module tb_count_seq_checker;

  localparam int WIDTH    = 4;
  localparam int LOCK_CNT = 3;
  localparam int ERR_W    = 8;
  localparam int ERR_W_S  = 2;
  localparam int MOD      = 1 << WIDTH;
  localparam int SAT_M    = (1 << ERR_W) - 1;
  localparam int SAT_S    = (1 << ERR_W_S) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] count_in = '0;

  logic               locked, err_pulse, wrap_pulse;
  logic [ERR_W-1:0]   err_count, wrap_count;
  logic [1:0]         state;
  logic               locked_s, err_pulse_s, wrap_pulse_s;
  logic [ERR_W_S-1:0] err_count_s, wrap_count_s;
  logic [1:0]         state_s;

  count_seq_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .count_in(count_in),
    .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse),
    .err_count(err_count), .wrap_count(wrap_count), .state(state)
  );

  count_seq_checker #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .ERR_W(ERR_W_S)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .count_in(count_in),
    .locked(locked_s), .err_pulse(err_pulse_s), .wrap_pulse(wrap_pulse_s),
    .err_count(err_count_s), .wrap_count(wrap_count_s), .state(state_s)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: mode 0 idle, 1 acquiring, 2 locked; tallies kept unbounded.
  int m_mode, m_prev, m_run, m_err, m_wrap;
  bit m_ep, m_wp;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_prev = 0; m_run = 0; m_err = 0; m_wrap = 0;
    m_ep = 0; m_wp = 0;
  endfunction

  function automatic void model_step(input bit e, input bit c, input int v);
    bit good;
    m_ep = 0;
    m_wp = 0;
    if (c) begin
      m_mode = 0; m_run = 0; m_err = 0; m_wrap = 0;
      return;
    end
    if (!e) return;
    good = (v == (m_prev + 1) % MOD);
    if (m_mode == 0) begin
      m_run = 0;
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (good) begin
        m_run++;
        if (m_run >= LOCK_CNT) m_mode = 2;
      end else begin
        m_run = 0;
      end
    end else begin
      if (good) begin
        if (m_prev == MOD - 1 && v == 0) begin
          m_wp = 1;
          m_wrap++;
        end
      end else begin
        m_ep = 1;
        m_err++;
        m_mode = 1;
        m_run = 0;
      end
    end
    m_prev = v;
  endfunction

  task automatic check_all(input string ctx);
    check({ctx, ".locked"},     int'(locked),      int'(m_mode == 2));
    check({ctx, ".state"},      int'(state),       m_mode);
    check({ctx, ".err_pulse"},  int'(err_pulse),   int'(m_ep));
    check({ctx, ".wrap_pulse"}, int'(wrap_pulse),  int'(m_wp));
    check({ctx, ".err_count"},  int'(err_count),   sat(m_err, SAT_M));
    check({ctx, ".wrap_count"}, int'(wrap_count),  sat(m_wrap, SAT_M));
    check({ctx, ".err_count_s"},  int'(err_count_s),  sat(m_err, SAT_S));
    check({ctx, ".wrap_count_s"}, int'(wrap_count_s), sat(m_wrap, SAT_S));
  endtask

  task automatic step(input bit e, input bit c, input int v, input string ctx);
    @(negedge clk);
    en = e;
    clr = c;
    count_in = v[WIDTH-1:0];
    @(posedge clk);
    model_step(e, c, v);
    #1;
    check_all(ctx);
  endtask

  task automatic run_seq(input int from, input int n, input string ctx);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, (from + i) % MOD, ctx);
  endtask

  // Asserts reset a few ns after an edge, checks outputs before the next edge.
  task automatic async_reset(input string ctx);
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    clr = 1'b0;
    #1;
    model_reset();
    check_all(ctx);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int p;
    int seen;
    int cur;
    int r;
    bit e, c;
    int v;

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Lock on 0,1,2,3
    run_seq(0, 4, "t1");
    check("t1.locked_const", int'(locked), 1);
    check("t1.state_const", int'(state), 2);

    // Wrap 4..15,0
    run_seq(4, 12, "t2");
    step(1'b1, 1'b0, 0, "t2w");
    check("t2.wrap_pulse_const", int'(wrap_pulse), 1);
    check("t2.wrap_count_const", int'(wrap_count), 1);
    step(1'b1, 1'b0, 1, "t2n");
    check("t2.wrap_pulse_drop", int'(wrap_pulse), 0);

    // Error and relock: 6,6,7,8,9 from prev=5
    run_seq(2, 4, "t3p");
    step(1'b1, 1'b0, 6, "t3a");
    step(1'b1, 1'b0, 6, "t3b");
    check("t3.err_pulse_const", int'(err_pulse), 1);
    check("t3.state_const", int'(state), 1);
    run_seq(7, 3, "t3r");
    check("t3.relock_const", int'(locked), 1);

    // Enable gating at prev=5
    run_seq(10, 6, "t4p");
    run_seq(0, 6, "t4q");
    step(1'b0, 1'b0, 9, "t4g0");
    step(1'b0, 1'b0, 9, "t4g1");
    step(1'b1, 1'b0, 6, "t4e");
    check("t4.no_err_const", int'(err_pulse), 0);
    check("t4.locked_const", int'(locked), 1);

    // Saturation: five locked mismatches with relock between
    p = 6;
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, p, "t5m");
      seen += int'(err_pulse_s);
      run_seq((p + 1) % MOD, 3, "t5r");
      p = (p + 3) % MOD;
    end
    check("t5.pulses_seen", seen, 5);
    check("t5.err_sat_const", int'(err_count_s), 3);

    // Async reset mid-cycle while locked with non-zero tallies
    async_reset("t6rst");
    check("t6.err_zero_const", int'(err_count), 0);
    run_seq(3, 4, "t6a");
    step(1'b1, 1'b0, 6, "t6b");
    run_seq(7, 3, "t6c");
    step(1'b1, 1'b1, 10, "t6clr");
    check("t6.clr_state_const", int'(state), 0);
    step(1'b1, 1'b0, 4, "t6d");
    run_seq(5, 3, "t6e");
    check("t6.relock_const", int'(locked), 1);

    // Randomized phase
    cur = 7;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      e = (r < 85);
      c = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 9) < 8) v = (cur + 1) % MOD;
      else v = int'($urandom_range(0, MOD - 1));
      step(e, c, v, "rnd");
      if (e) cur = v;
      if ($urandom_range(0, 499) == 0) async_reset("rndrst");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
